// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between an instruction-fetch requester (IF) and a
// load/store requester (LS). One transaction is in flight at a time:
//   IDLE  : grant one requester (round-robin on conflict), latch its request
//   ISSUE : drive the latched request onto the RAM port for exactly one cycle
//   RESP  : present read data to the owner until it accepts
//
// Ports
//   clock, reset          : single clock, synchronous active-low reset
//   if_req_* / if_resp_*  : fetch read request and response (valid/ready)
//   ls_req_* / ls_resp_*  : load/store request (wen/wdata/wstrb) and response
//   ram_*                 : shared RAM port; ram_rdata reflects ram_raddr of the previous edge
module ram_arbiter #(
  parameter logic [63:0] RESET_ADDR = 64'h0000_0000_8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  // Instruction fetch
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_req_addr,
  output logic        if_resp_valid,
  input  logic        if_resp_ready,
  output logic [63:0] if_resp_data,
  // Load/store
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [63:0] ls_req_addr,
  input  logic        ls_req_wen,
  input  logic [63:0] ls_req_wdata,
  input  logic [7:0]  ls_req_wstrb,
  output logic        ls_resp_valid,
  input  logic        ls_resp_ready,
  output logic [63:0] ls_resp_data,
  // Shared RAM port
  output logic [63:0] ram_raddr,
  input  logic [63:0] ram_rdata,
  output logic [63:0] ram_waddr,
  output logic [63:0] ram_wdata,
  output logic [7:0]  ram_wstrb,
  output logic        ram_wen
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e      state_q, state_d;
  logic        last_ls_q, last_ls_d;    // 1: LS was granted last, 0: IF
  logic        owner_ls_q, owner_ls_d;  // owner of the transaction in flight
  logic [63:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic [63:0] resp_q, resp_d;
  logic        first_q, first_d;        // first cycle of RESP

  logic        grant_ls, grant_if;
  logic        resp_fire;
  logic        in_issue, in_resp;
  logic [63:0] resp_data;

  // LS wins a conflict unless it was the last one granted.
  assign grant_ls  = ls_req_valid & (~if_req_valid | ~last_ls_q);
  assign grant_if  = if_req_valid & ~grant_ls;
  assign in_issue  = (state_q == StIssue);
  assign in_resp   = (state_q == StResp);
  assign resp_fire = in_resp & (owner_ls_q ? ls_resp_ready : if_resp_ready);

  // The RAM read lands on the RESP entry edge, so the first RESP cycle forwards the RAM bus
  // directly and the same value is held in resp_q for any later cycles.
  assign resp_data = (in_resp && first_q) ? ram_rdata : resp_q;

  always_comb begin
    state_d    = state_q;
    last_ls_d  = last_ls_q;
    owner_ls_d = owner_ls_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    resp_d     = resp_q;
    first_d    = 1'b0;
    if_req_ready = 1'b0;
    ls_req_ready = 1'b0;

    unique case (state_q)
      StIdle: begin
        if_req_ready = grant_if & reset;
        ls_req_ready = grant_ls & reset;
        if (grant_if || grant_ls) begin
          state_d    = StIssue;
          owner_ls_d = grant_ls;
          last_ls_d  = grant_ls;
          addr_d     = grant_ls ? ls_req_addr : if_req_addr;
          wen_d      = grant_ls & ls_req_wen;
          wdata_d    = grant_ls ? ls_req_wdata : 64'h0;
          wstrb_d    = grant_ls ? ls_req_wstrb : 8'h0;
        end
      end
      StIssue: begin
        state_d = StResp;
        first_d = 1'b1;
      end
      StResp: begin
        if (first_q) resp_d = ram_rdata;
        if (resp_fire) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      last_ls_q  <= 1'b0;
      owner_ls_q <= 1'b0;
      addr_q     <= RESET_ADDR;
      wen_q      <= 1'b0;
      wdata_q    <= 64'h0;
      wstrb_q    <= 8'h0;
      resp_q     <= 64'h0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_ls_q  <= last_ls_d;
      owner_ls_q <= owner_ls_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      resp_q     <= resp_d;
      first_q    <= first_d;
    end
  end

  // Gating with reset keeps an abandoned store from being written on the reset edge.
  assign ram_raddr = addr_q;
  assign ram_waddr = addr_q;
  assign ram_wen   = in_issue & wen_q & reset;
  assign ram_wdata = in_issue ? wdata_q : 64'h0;
  assign ram_wstrb = in_issue ? wstrb_q : 8'h0;

  assign if_resp_valid = in_resp & ~owner_ls_q & reset;
  assign ls_resp_valid = in_resp & owner_ls_q & reset;
  assign if_resp_data  = resp_data;
  assign ls_resp_data  = resp_data;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a registered-read RAM model and an expected-response
// scoreboard (pushed on request handshake, popped on response).
module tb_ram_arbiter;

  localparam logic [63:0] RstA = 64'h0000_0000_8000_0000;
  localparam logic [63:0] AIf  = 64'h0000_0000_8000_0100;
  localparam logic [63:0] ALs  = 64'h0000_0000_8000_0200;
  localparam logic [63:0] Mark = 64'h0000_0000_8000_0300;
  localparam logic [63:0] Bad  = 64'h0000_0000_BAD0_0000;
  localparam logic [63:0] D0   = 64'h1122_3344_5566_7788;
  localparam logic [63:0] DIf  = 64'hA1A1_A1A1_0101_0101;
  localparam logic [63:0] DLs  = 64'hB2B2_B2B2_0202_0202;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_req_valid = 1'b0, if_req_ready, if_resp_valid, if_resp_ready = 1'b0;
  logic [63:0] if_req_addr = 64'h0, if_resp_data;
  logic        ls_req_valid = 1'b0, ls_req_ready, ls_req_wen = 1'b0, ls_resp_valid;
  logic        ls_resp_ready = 1'b0;
  logic [63:0] ls_req_addr = 64'h0, ls_req_wdata = 64'h0, ls_resp_data;
  logic [7:0]  ls_req_wstrb = 8'h0;
  logic [63:0] ram_raddr, ram_waddr, ram_wdata;
  logic [63:0] ram_rdata = 64'h0;
  logic [7:0]  ram_wstrb;
  logic        ram_wen;

  int checks = 0;
  int failures = 0;
  int wen_cnt = 0, mark_cnt = 0, rv_cnt = 0;

  typedef struct {
    logic        is_ls;
    logic [63:0] data;
    logic        chk;
  } exp_t;
  exp_t sb[$];

  logic [63:0] mem [logic [63:0]];

  ram_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_req_addr   (if_req_addr),
    .if_resp_valid (if_resp_valid),
    .if_resp_ready (if_resp_ready),
    .if_resp_data  (if_resp_data),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_req_addr   (ls_req_addr),
    .ls_req_wen    (ls_req_wen),
    .ls_req_wdata  (ls_req_wdata),
    .ls_req_wstrb  (ls_req_wstrb),
    .ls_resp_valid (ls_resp_valid),
    .ls_resp_ready (ls_resp_ready),
    .ls_resp_data  (ls_resp_data),
    .ram_raddr     (ram_raddr),
    .ram_rdata     (ram_rdata),
    .ram_waddr     (ram_waddr),
    .ram_wdata     (ram_wdata),
    .ram_wstrb     (ram_wstrb),
    .ram_wen       (ram_wen)
  );

  always #5 clock = ~clock;

  // RAM model: registered read (read-before-write), byte-strobed write.
  always @(posedge clock) begin
    logic [63:0] rd, old;
    rd = mem.exists(ram_raddr) ? mem[ram_raddr] : 64'h0;
    if (ram_wen) begin
      old = mem.exists(ram_waddr) ? mem[ram_waddr] : 64'h0;
      for (int b = 0; b < 8; b++) if (ram_wstrb[b]) old[b*8 +: 8] = ram_wdata[b*8 +: 8];
      mem[ram_waddr] = old;
    end
    ram_rdata <= rd;
  end

  always @(negedge clock) begin
    if (ram_wen) wen_cnt++;
    if (ram_raddr == Mark) mark_cnt++;
    if (if_resp_valid || ls_resp_valid) rv_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs one transaction from IDLE; entered and left away from the clock edge.
  task automatic do_txn(input logic is_ls, input logic [63:0] addr, input logic wen,
                        input logic [63:0] wdata, input logic [7:0] wstrb,
                        input logic [63:0] exp_data, input logic chk, input int stall,
                        input string tag);
    exp_t        e;
    logic        ok;
    logic [63:0] d0;
    if_resp_ready = 1'b0;
    ls_resp_ready = 1'b0;
    if (is_ls) begin
      ls_req_valid = 1'b1; ls_req_addr = addr; ls_req_wen = wen;
      ls_req_wdata = wdata; ls_req_wstrb = wstrb;
    end else begin
      if_req_valid = 1'b1; if_req_addr = addr;
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (is_ls ? ls_req_ready : if_req_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "/req_handshake"}, ok, 1);
    if (!ok) begin
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      return;
    end
    sb.push_back('{is_ls, exp_data, chk});
    tick();  // ISSUE
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    #1;
    check({tag, "/issue_raddr"}, ram_raddr, addr);
    check({tag, "/issue_waddr"}, ram_waddr, addr);
    check({tag, "/issue_wen"}, ram_wen, is_ls & wen);
    check({tag, "/issue_wdata"}, ram_wdata, is_ls ? wdata : 64'h0);
    check({tag, "/issue_wstrb"}, ram_wstrb, is_ls ? wstrb : 8'h0);
    check({tag, "/issue_ready"}, {if_req_ready, ls_req_ready}, 0);
    tick();  // RESP
    #1;
    check({tag, "/resp_valid"}, is_ls ? ls_resp_valid : if_resp_valid, 1);
    check({tag, "/other_valid"}, is_ls ? if_resp_valid : ls_resp_valid, 0);
    check({tag, "/resp_wen"}, {ram_wen, ram_wstrb}, 0);
    e  = sb.pop_front();
    d0 = is_ls ? ls_resp_data : if_resp_data;
    if (e.chk) check({tag, "/resp_data"}, d0, e.data);
    if (stall > 0) begin
      // Competing request while stalled must not be granted.
      if (is_ls) begin
        if_req_valid = 1'b1; if_req_addr = Bad;
      end else begin
        ls_req_valid = 1'b1; ls_req_addr = Bad; ls_req_wen = 1'b0;
      end
      for (int i = 0; i < stall; i++) begin
        tick();
        #1;
        check({tag, "/stall_valid"}, is_ls ? ls_resp_valid : if_resp_valid, 1);
        check({tag, "/stall_data"}, is_ls ? ls_resp_data : if_resp_data, d0);
        check({tag, "/stall_ready"}, {if_req_ready, ls_req_ready}, 0);
      end
      if_req_valid = 1'b0;
      ls_req_valid = 1'b0;
    end
    if (is_ls) ls_resp_ready = 1'b1;
    else       if_resp_ready = 1'b1;
    tick();
    if_resp_ready = 1'b0;
    ls_resp_ready = 1'b0;
    #1;
    check({tag, "/resp_done"}, {if_resp_valid, ls_resp_valid}, 0);
  endtask

  initial begin
    exp_t        e;
    int          n, cyc, w0, m0, r0;
    logic        pend;
    logic [63:0] pend_addr;
    logic        gls[4];
    int          gcyc[4];

    mem[RstA] = D0;
    mem[AIf]  = DIf;
    mem[ALs]  = DLs;

    // Reset: both requesters valid, nothing may be granted.
    if_req_valid = 1'b1; if_req_addr = AIf;
    ls_req_valid = 1'b1; ls_req_addr = ALs; ls_req_wen = 1'b0;
    if_resp_ready = 1'b1; ls_resp_ready = 1'b1;
    repeat (3) tick();
    #1;
    check("rst/ready", {if_req_ready, ls_req_ready}, 0);
    check("rst/raddr", ram_raddr, RstA);
    check("rst/waddr", ram_waddr, RstA);
    check("rst/wen", ram_wen, 0);
    check("rst/resp_valid", {if_resp_valid, ls_resp_valid}, 0);
    check("rst/resp_data", if_resp_data, 64'h0);

    // Round-robin from reset with both requesters continuously valid.
    reset = 1'b1;
    #1;
    n = 0; cyc = 0; pend = 1'b0; pend_addr = 64'h0;
    while (cyc < 60 && !(n == 4 && sb.size() == 0)) begin
      if (pend) check("rr/issue_raddr", ram_raddr, pend_addr);
      pend = 1'b0;
      if (n < 4 && ls_req_valid && ls_req_ready) begin
        gls[n] = 1'b1; gcyc[n] = cyc; n++;
        sb.push_back('{1'b1, DLs, 1'b1});
        pend = 1'b1; pend_addr = ALs;
      end else if (n < 4 && if_req_valid && if_req_ready) begin
        gls[n] = 1'b0; gcyc[n] = cyc; n++;
        sb.push_back('{1'b0, DIf, 1'b1});
        pend = 1'b1; pend_addr = AIf;
      end
      if ((if_resp_valid && if_resp_ready) || (ls_resp_valid && ls_resp_ready)) begin
        check("rr/resp_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("rr/resp_owner", ls_resp_valid, e.is_ls);
          check("rr/resp_data", ls_resp_valid ? ls_resp_data : if_resp_data, e.data);
        end
      end
      tick();
      #1;
      if (n == 4) begin
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
      end
      cyc++;
    end
    check("rr/grant_count", n, 4);
    for (int i = 0; i < 4; i++) begin
      check("rr/grant_order", gls[i], (i % 2) == 0);
      check("rr/grant_cycle", gcyc[i], 3 * i);
    end
    if_resp_ready = 1'b0;
    ls_resp_ready = 1'b0;

    // Withdrawn IF request while LS holds the grant (last grant was IF).
    m0 = mark_cnt;
    if_req_valid = 1'b1; if_req_addr = Mark;
    ls_req_valid = 1'b1; ls_req_addr = ALs; ls_req_wen = 1'b0;
    #1;
    check("wd/ls_ready", ls_req_ready, 1);
    check("wd/if_ready", if_req_ready, 0);
    tick();
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    #1;
    check("wd/issue_raddr", ram_raddr, ALs);
    tick();
    ls_resp_ready = 1'b1;
    #1;
    check("wd/resp_data", ls_resp_data, DLs);
    repeat (5) tick();
    ls_resp_ready = 1'b0;
    check("wd/hold_raddr", ram_raddr, ALs);
    check("wd/never_issued", mark_cnt - m0, 0);

    // IF read, no write strobe ever.
    w0 = wen_cnt;
    do_txn(1'b0, RstA, 1'b0, 64'h0, 8'h0, D0, 1'b1, 0, "if_read");
    check("if_read/no_wen", wen_cnt - w0, 0);

    // LS store then load-back.
    w0 = wen_cnt;
    do_txn(1'b1, 64'h8000_0010, 1'b1, 64'hDEAD_BEEF, 8'h0F, 64'h0, 1'b0, 0, "store");
    check("store/wen_once", wen_cnt - w0, 1);
    do_txn(1'b1, 64'h8000_0010, 1'b0, 64'h0, 8'h0, 64'h0000_0000_DEAD_BEEF, 1'b1, 0, "load");
    check("load/low32", ls_resp_data[31:0], 32'hDEAD_BEEF);

    // Stalled LS response.
    do_txn(1'b1, RstA, 1'b0, 64'h0, 8'h0, D0, 1'b1, 5, "stall");

    // Reset during ISSUE of a store.
    ls_req_valid = 1'b1; ls_req_addr = 64'h8000_0020; ls_req_wen = 1'b1;
    ls_req_wdata = 64'h55; ls_req_wstrb = 8'hFF;
    ls_resp_ready = 1'b1;
    #1;
    check("rst_issue/ready", ls_req_ready, 1);
    tick();
    ls_req_valid = 1'b0;
    check("rst_issue/wen_issue", ram_wen, 1);
    reset = 1'b0;
    tick();
    r0 = rv_cnt;
    check("rst_issue/wen_after", ram_wen, 0);
    check("rst_issue/raddr", ram_raddr, RstA);
    check("rst_issue/resp_valid", {if_resp_valid, ls_resp_valid}, 0);
    reset = 1'b1;
    repeat (6) tick();
    check("rst_issue/no_resp", rv_cnt - r0, 0);
    ls_resp_ready = 1'b0;

    // Last grant is IF again after reset: LS wins the next conflict.
    if_req_valid = 1'b1; if_req_addr = AIf;
    ls_req_valid = 1'b1; ls_req_addr = ALs; ls_req_wen = 1'b0;
    #1;
    check("post_rst/grant", {if_req_ready, ls_req_ready}, 2'b01);
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
